// File: rtl/ppm_arbiter.sv
// ppm_arbiter
//   Round-robin front end that shares a single serial/parallel multiplier (PPM)
//   among NREQ requesters. One request is granted at a time. Its operands are
//   latched and the PPM is started. The product is returned tagged with the
//   requester id.
//
// Ports
//   clk, reset                 clock (rising edge), async active-high reset
//   req_valid/req_mp/req_mc    per-requester request; slice i = [i*W +: W]
//   req_ready                  one-hot accept, combinational, IDLE only
//   rsp_valid/rsp_id/rsp_p     response held until rsp_ready
//   rsp_err                    timed-out operation flag
//   busy                       high outside IDLE
//   mul_resetn/mul_start       PPM control (reset active-low, start pulse)
//   mul_mp/mul_mc              registered PPM operands
//   mul_p/mul_done             PPM result; done may stay high until next start
//
// Build option
//   PPM_TIMEOUT_EN  enables the WAIT timeout, which returns rsp_err=1 and
//                   pulses mul_resetn low for one cycle.
module ppm_arbiter #(
  parameter int W       = 32,
  parameter int NREQ    = 4,
  parameter int MIN_LAT = 2,
  parameter int TIMEOUT = 80
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*W-1:0]        req_mp,
  input  logic [NREQ*W-1:0]        req_mc,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [2*W-1:0]           rsp_p,
  output logic                     rsp_err,
  input  logic                     rsp_ready,
  output logic                     busy,
  output logic                     mul_resetn,
  output logic                     mul_start,
  output logic [W-1:0]             mul_mp,
  output logic [W-1:0]             mul_mc,
  input  logic [2*W-1:0]           mul_p,
  input  logic                     mul_done
);

  localparam int IDW     = $clog2(NREQ);
  localparam int CNT_MAX = (TIMEOUT > MIN_LAT) ? TIMEOUT : MIN_LAT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t          state_q;
  logic [IDW-1:0]  rr_ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_inc;
  logic            done_ok;
  logic            abort_q;
  logic            gnt_vld;
  logic [IDW-1:0]  gnt_id;

  // Requester index base+off, wrapping at NREQ-1 -> 0.
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base,
                                              input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= 32'(NREQ)) s = s - 32'(NREQ);
    return s[IDW-1:0];
  endfunction

  // First valid requester at or after rr_ptr_q.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!gnt_vld && req_valid[wrap_idx(rr_ptr_q, k)]) begin
        gnt_vld = 1'b1;
        gnt_id  = wrap_idx(rr_ptr_q, k);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && gnt_vld && !reset) req_ready[gnt_id] = 1'b1;
  end

  assign cnt_inc    = (cnt_q == CW'(CNT_MAX)) ? cnt_q : cnt_q + 1'b1;
  // A done seen within MIN_LAT cycles of start belongs to the previous operation.
  assign done_ok    = mul_done && (cnt_q >= CW'(MIN_LAT));
  assign busy       = (state_q != IDLE);
  assign mul_resetn = ~(reset | abort_q);

`ifndef PPM_TIMEOUT_EN
  assign abort_q = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_p     <= '0;
      mul_start <= 1'b0;
      mul_mp    <= '0;
      mul_mc    <= '0;
`ifdef PPM_TIMEOUT_EN
      rsp_err   <= 1'b0;
      abort_q   <= 1'b0;
`endif
    end else begin
      mul_start <= 1'b0;
`ifdef PPM_TIMEOUT_EN
      abort_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            mul_mp    <= req_mp[gnt_id*W +: W];
            mul_mc    <= req_mc[gnt_id*W +: W];
            rsp_id    <= gnt_id;
            mul_start <= 1'b1;
            state_q   <= START;
          end
        end
        START: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_inc;
          if (done_ok) begin
            rsp_p     <= mul_p;
            rsp_valid <= 1'b1;
`ifdef PPM_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            state_q   <= RESP;
          end
`ifdef PPM_TIMEOUT_EN
          // Decided on the incremented count so the error response appears
          // exactly TIMEOUT cycles after WAIT is entered.
          else if (cnt_inc == CW'(TIMEOUT)) begin
            rsp_p     <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            abort_q   <= 1'b1;
            state_q   <= RESP;
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr_q  <= (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
